// File: rtl/output_packer.sv
// output_packer: return path of the FP multiplier datapath.
// Takes the unpacked product fields (sign, biased exponent sum, raw 1.13 x 1.13
// significand product) and emits one packed IEEE-754 single-precision word.
// Stage 1 normalizes and rounds to nearest-even. The output stage then applies
// the nan/zero/overflow/underflow priority and packs the word.
// The two stages use a valid/ready handshake and hold two results in total.
// Optional feature: define OUTPUT_PACKER_FLAGS_EN to add the status_flags port,
// which carries {overflow, underflow, inexact} aligned with result_word.
module output_packer #(
    parameter int          EXP_W    = 10,
    parameter logic [31:0] NAN_WORD = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             res_sign,
    input  logic [EXP_W-1:0] res_exp,
    input  logic [27:0]      res_mant,
    input  logic             res_zero,
    input  logic             res_nan,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef OUTPUT_PACKER_FLAGS_EN
    output logic [2:0]       status_flags,
`endif
    output logic [31:0]      result_word
);

    // The exponent is carried one bit wider than the input.
    // The +1 from normalization and the +1 from a rounding carry then cannot wrap.
    localparam logic signed [EXP_W:0] EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic signed [EXP_W:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W:0] EXP_MAX  = {{(EXP_W-7){1'b0}}, 8'hFF};

    // Stage-1 register state
    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W:0]   s1_exp;
    logic [22:0]             s1_frac;
    logic                    s1_zero;
    logic                    s1_nan;
`ifdef OUTPUT_PACKER_FLAGS_EN
    logic                    s1_inexact;
`endif

    // Normalize/round combinational results
    logic signed [EXP_W:0]   exp_ext;
    logic signed [EXP_W:0]   exp_pre;
    logic signed [EXP_W:0]   exp_rnd;
    logic [22:0]             frac_pre;
    logic [22:0]             frac_rnd;
    logic [23:0]             frac_sum;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;

    // Pack stage combinational results
    logic                    out_load;
    logic                    s1_advance;
    logic                    in_fire;
    logic                    is_ovf;
    logic                    is_unf;
    logic [31:0]             pack_word;

    // Handshake: the output register refills when it is empty or being drained.
    // S1 moves forward on that same condition.
    always_comb begin
        out_load   = !out_valid || out_ready;
        s1_advance = out_load;
        in_ready   = reset && (!s1_valid || s1_advance);
        in_fire    = in_valid && in_ready;
    end

    // Normalize the [1,4) product to 1.23 and round to nearest-even.
    // A carry out of the fraction bumps the exponent.
    always_comb begin
        exp_ext = {res_exp[EXP_W-1], res_exp};
        if (res_mant[27]) begin
            frac_pre = res_mant[26:4];
            guard    = res_mant[3];
            sticky   = |res_mant[2:0];
            exp_pre  = exp_ext + EXP_ONE;
        end else begin
            frac_pre = res_mant[25:3];
            guard    = res_mant[2];
            sticky   = |res_mant[1:0];
            exp_pre  = exp_ext;
        end
        round_up = guard && (sticky || frac_pre[0]);
        frac_sum = {1'b0, frac_pre} + {23'b0, round_up};
        if (frac_sum[23]) begin
            frac_rnd = 23'b0;
            exp_rnd  = exp_pre + EXP_ONE;
        end else begin
            frac_rnd = frac_sum[22:0];
            exp_rnd  = exp_pre;
        end
    end

    // Stage-1 register: captures the rounded fields when a new input is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_frac    <= '0;
            s1_zero    <= 1'b0;
            s1_nan     <= 1'b0;
`ifdef OUTPUT_PACKER_FLAGS_EN
            s1_inexact <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_fire) begin
                s1_sign    <= res_sign;
                s1_exp     <= exp_rnd;
                s1_frac    <= frac_rnd;
                s1_zero    <= res_zero;
                s1_nan     <= res_nan;
`ifdef OUTPUT_PACKER_FLAGS_EN
                s1_inexact <= guard || sticky;
`endif
            end
        end
    end

    // Range check and pack.
    // Priority order: nan, then zero, then overflow to infinity, then underflow flush, then normal.
    always_comb begin
        is_ovf = (s1_exp >= EXP_MAX);
        is_unf = (s1_exp <= EXP_ZERO);
        if (s1_nan) begin
            pack_word = NAN_WORD;
        end else if (s1_zero) begin
            pack_word = {s1_sign, 31'b0};
        end else if (is_ovf) begin
            pack_word = {s1_sign, 8'hFF, 23'b0};
        end else if (is_unf) begin
            pack_word = {s1_sign, 31'b0};
        end else begin
            pack_word = {s1_sign, s1_exp[7:0], s1_frac};
        end
    end

`ifdef OUTPUT_PACKER_FLAGS_EN
    logic [2:0] flags_next;

    // Status flags follow the same priority. Nan and zero results raise none.
    always_comb begin
        flags_next = 3'b000;
        if (s1_nan || s1_zero) begin
            flags_next = 3'b000;
        end else if (is_ovf) begin
            flags_next = 3'b101;
        end else if (is_unf) begin
            flags_next = 3'b011;
        end else begin
            flags_next = {2'b00, s1_inexact};
        end
    end

    // Flags register moves with result_word and holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_flags <= 3'b000;
        end else if (out_load && s1_valid) begin
            status_flags <= flags_next;
        end
    end
`endif

    // Output register: refills from S1 when empty or draining.
    // It holds its word while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            result_word <= 32'b0;
        end else if (out_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result_word <= pack_word;
            end
        end
    end

endmodule

// File: tb/tb_output_packer.sv
// tb_output_packer: directed-vector bench for output_packer.
// It covers single results, rounding, range cases, backpressure and reset in mid-stream.
// Expected words were worked out by hand from the field values.
module tb_output_packer;

    localparam int EXP_W = 10;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             res_sign;
    logic [EXP_W-1:0] res_exp;
    logic [27:0]      res_mant;
    logic             res_zero;
    logic             res_nan;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result_word;
`ifdef OUTPUT_PACKER_FLAGS_EN
    logic [2:0]       status_flags;
`endif

    int checks;
    int errors;

    output_packer #(.EXP_W(EXP_W), .NAN_WORD(32'h7FC00000)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .res_sign    (res_sign),
        .res_exp     (res_exp),
        .res_mant    (res_mant),
        .res_zero    (res_zero),
        .res_nan     (res_nan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef OUTPUT_PACKER_FLAGS_EN
        .status_flags(status_flags),
`endif
        .result_word (result_word)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check passes through here
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    // Drive one set of input fields with in_valid raised
    task automatic apply_stimulus(input logic sign, input logic [EXP_W-1:0] exp_in,
                                  input logic [27:0] mant, input logic zero, input logic nan);
        in_valid = 1'b1;
        res_sign = sign;
        res_exp  = exp_in;
        res_mant = mant;
        res_zero = zero;
        res_nan  = nan;
    endtask

    // Send one input with no backpressure.
    // Check that it is not yet visible one cycle after accept, then check the word two cycles after accept.
    task automatic send_one(input string tag, input logic sign, input logic [EXP_W-1:0] exp_in,
                            input logic [27:0] mant, input logic zero, input logic nan,
                            input logic [31:0] exp_word, input logic [2:0] exp_flags);
        @(negedge clk);
        out_ready = 1'b1;
        apply_stimulus(sign, exp_in, mant, zero, nan);
        #1;
        check_output({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_output({tag, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check_output({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_output({tag, "_word"}, result_word, exp_word);
`ifdef OUTPUT_PACKER_FLAGS_EN
        check_output({tag, "_flags"}, {29'b0, status_flags}, {29'b0, exp_flags});
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        res_sign  = 1'b0;
        res_exp   = '0;
        res_mant  = '0;
        res_zero  = 1'b0;
        res_nan   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_word", result_word, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Main function and rounding
        send_one("one_x_one",  1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 3'b000);
        send_one("norm_1p5sq", 1'b0, 10'd127, 28'h9000000, 1'b0, 1'b0, 32'h40100000, 3'b000);
        send_one("rne_odd",    1'b0, 10'd127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 3'b001);
        send_one("rne_even",   1'b0, 10'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 3'b001);
        send_one("rnd_carry",  1'b0, 10'd127, 28'h7FFFFFF, 1'b0, 1'b0, 32'h40000000, 3'b001);
        send_one("neg_norm",   1'b1, 10'd130, 28'h4000000, 1'b0, 1'b0, 32'hC1000000, 3'b000);

        // Range and specials
        send_one("max_normal", 1'b0, 10'd253, 28'h8000000, 1'b0, 1'b0, 32'h7F000000, 3'b000);
        send_one("overflow",   1'b0, 10'd254, 28'h8000000, 1'b0, 1'b0, 32'h7F800000, 3'b101);
        send_one("min_normal", 1'b0, 10'd1,   28'h4000000, 1'b0, 1'b0, 32'h00800000, 3'b000);
        send_one("underflow",  1'b1, 10'd0,   28'h4000000, 1'b0, 1'b0, 32'h80000000, 3'b011);
        send_one("neg_exp",    1'b0, 10'h3FB, 28'h4000000, 1'b0, 1'b0, 32'h00000000, 3'b011);
        send_one("zero_in",    1'b1, 10'd127, 28'h4000000, 1'b1, 1'b0, 32'h80000000, 3'b000);
        send_one("nan_in",     1'b0, 10'd127, 28'h4000000, 1'b0, 1'b1, 32'h7FC00000, 3'b000);

        // Backpressure: three back-to-back inputs with out_ready held low
        @(negedge clk);
        out_ready = 1'b0;
        apply_stimulus(1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0);
        #1 check_output("bp_acc_a", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 10'd127, 28'h9000000, 1'b0, 1'b0);
        #1 check_output("bp_acc_b", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 10'd127, 28'h400000C, 1'b0, 1'b0);
        #1 check_output("bp_block_c", {31'b0, in_ready}, 32'd0);
        check_output("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check_output("bp_hold_word1", result_word, 32'h3F800000);
        @(negedge clk);
        check_output("bp_still_block", {31'b0, in_ready}, 32'd0);
        check_output("bp_hold_word2", result_word, 32'h3F800000);
        // Pipeline full: drain and accept happen on the same edge
        out_ready = 1'b1;
        #1 check_output("bp_full_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_output("bp_out_b", result_word, 32'h40100000);
        @(negedge clk);
        check_output("bp_out_c", result_word, 32'h3F800002);
        check_output("bp_out_c_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check_output("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset in mid-stream with two results in flight
        out_ready = 1'b0;
        apply_stimulus(1'b0, 10'd128, 28'h4000000, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, 10'd129, 28'h4000000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_output("mid_two_inflight", {31'b0, out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check_output("mid_rst_word", result_word, 32'd0);
        check_output("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_output("mid_no_stale", {31'b0, out_valid}, 32'd0);
        end
        send_one("post_rst", 1'b0, 10'd127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
